// File: rtl/alu_arbiter_if.sv
// Bundle of the requester, shared-ALU and response signals of alu_arbiter.
// The slave modport is the arbiter's view; the master modport is the view
// of whatever drives the requests, models the ALU and consumes responses.
interface alu_arbiter_if;

   // requester 0
   logic        req0_valid_i;
   logic [31:0] req0_src1_i;
   logic [31:0] req0_src2_i;
   logic [3:0]  req0_ctrl_i;
   logic        req0_ready_o;

   // requester 1
   logic        req1_valid_i;
   logic [31:0] req1_src1_i;
   logic [31:0] req1_src2_i;
   logic [3:0]  req1_ctrl_i;
   logic        req1_ready_o;

   // shared ALU
   logic [31:0] alu_src1_o;
   logic [31:0] alu_src2_o;
   logic [3:0]  alu_ctrl_o;
   logic [31:0] alu_result_i;
   logic        alu_zero_i;

   // response channel and status
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic        resp_id_o;
   logic [31:0] resp_result_o;
   logic        resp_zero_o;
   logic        busy_o;
   logic [15:0] op_count_o;

   modport slave (
      input  req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
      input  req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
      input  alu_result_i, alu_zero_i,
      input  resp_ready_i,
      output req0_ready_o, req1_ready_o,
      output alu_src1_o, alu_src2_o, alu_ctrl_o,
      output resp_valid_o, resp_id_o, resp_result_o, resp_zero_o,
      output busy_o, op_count_o
   );

   modport master (
      output req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
      output req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
      output alu_result_i, alu_zero_i,
      output resp_ready_i,
      input  req0_ready_o, req1_ready_o,
      input  alu_src1_o, alu_src2_o, alu_ctrl_o,
      input  resp_valid_o, resp_id_o, resp_result_o, resp_zero_o,
      input  busy_o, op_count_o
   );

endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation is outstanding at a time: IDLE grants and latches the
// operands, EXEC drives the ALU and captures its result, RESP holds the
// response until the consumer takes it.
module alu_arbiter (
   input  logic          clk_i,
   input  logic          rst_i,
   alu_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] CTRL_NOP = 4'hF;

   state_t      state_q, state_d;
   logic        ptr_q,   ptr_d;
   logic [31:0] src1_q,  src1_d;
   logic [31:0] src2_q,  src2_d;
   logic [3:0]  ctrl_q,  ctrl_d;
   logic        id_q,    id_d;
   logic [31:0] result_q, result_d;
   logic        zero_q,  zero_d;
   logic [15:0] count_q, count_d;

   logic        gnt;
   logic        ready0;
   logic        ready1;
   logic [31:0] alu_src1;
   logic [31:0] alu_src2;
   logic [3:0]  alu_ctrl;

   // state register and datapath flops, cleared asynchronously
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         ptr_q    <= 1'b0;
         src1_q   <= '0;
         src2_q   <= '0;
         ctrl_q   <= CTRL_NOP;
         id_q     <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         src1_q   <= src1_d;
         src2_q   <= src2_d;
         ctrl_q   <= ctrl_d;
         id_q     <= id_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         count_q  <= count_d;
      end
   end

   // next-state, grant, ALU drive and response capture
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      src1_d   = src1_q;
      src2_d   = src2_q;
      ctrl_d   = ctrl_q;
      id_d     = id_q;
      result_d = result_q;
      zero_d   = zero_q;
      count_d  = count_q;
      gnt      = 1'b0;
      ready0   = 1'b0;
      ready1   = 1'b0;
      alu_src1 = '0;
      alu_src2 = '0;
      alu_ctrl = CTRL_NOP;

      unique case (state_q)
         IDLE: begin
            // rst_i gates the combinational readys so none leak during reset
            if (!rst_i && (bus.req0_valid_i || bus.req1_valid_i)) begin
               gnt = (bus.req0_valid_i && bus.req1_valid_i) ? ptr_q : bus.req1_valid_i;
               if (gnt) begin
                  ready1 = 1'b1;
                  src1_d = bus.req1_src1_i;
                  src2_d = bus.req1_src2_i;
                  ctrl_d = bus.req1_ctrl_i;
               end else begin
                  ready0 = 1'b1;
                  src1_d = bus.req0_src1_i;
                  src2_d = bus.req0_src2_i;
                  ctrl_d = bus.req0_ctrl_i;
               end
               id_d    = gnt;
               ptr_d   = ~gnt;
               state_d = EXEC;
            end
         end
         EXEC: begin
            alu_src1 = src1_q;
            alu_src2 = src2_q;
            alu_ctrl = ctrl_q;
            result_d = bus.alu_result_i;
            zero_d   = bus.alu_zero_i;
            state_d  = RESP;
         end
         RESP: begin
            if (bus.resp_ready_i) begin
               count_d = count_q + 16'd1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.req0_ready_o  = ready0;
   assign bus.req1_ready_o  = ready1;
   assign bus.alu_src1_o    = alu_src1;
   assign bus.alu_src2_o    = alu_src2;
   assign bus.alu_ctrl_o    = alu_ctrl;
   assign bus.resp_valid_o  = (state_q == RESP);
   assign bus.resp_id_o     = id_q;
   assign bus.resp_result_o = result_q;
   assign bus.resp_zero_o   = zero_q;
   assign bus.busy_o        = (state_q != IDLE);
   assign bus.op_count_o    = count_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The module SHALL have ports `clk_i`, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 The module SHALL have port `rst_i`, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The module SHALL have ports `req0_valid_i` / `req1_valid_i`, input, 1 bit each: requester 0/1 has an operation pending.
REQ-004 The module SHALL have ports `req0_src1_i`, `req0_src2_i`, `req1_src1_i`, `req1_src2_i`, input, 32 bits each: operands.
REQ-005 The module SHALL have ports `req0_ctrl_i` / `req1_ctrl_i`, input, 4 bits each: ALU operation code (0 and, 1 or, 2 add, 3 eq, 4 lt, 5 le, 6 sub, 7 slt, 8 mult, other codes nop).
REQ-006 The module SHALL have ports `req0_ready_o` / `req1_ready_o`, output, 1 bit each: the request is accepted this cycle.
REQ-007 The module SHALL have ports `alu_src1_o` / `alu_src2_o`, output, 32 bits each: operands driven to the shared ALU.
REQ-008 The module SHALL have port `alu_ctrl_o`, output, 4 bits: operation code driven to the shared ALU.
REQ-009 The module SHALL have port `alu_result_i`, input, 32 bits: ALU result (combinational in the ALU).
REQ-010 The module SHALL have port `alu_zero_i`, input, 1 bit: ALU zero flag.
REQ-011 The module SHALL have port `resp_valid_o`, output, 1 bit: a response is held.
REQ-012 The module SHALL have port `resp_ready_i`, input, 1 bit: the consumer takes the response.
REQ-013 The module SHALL have port `resp_id_o`, output, 1 bit: the requester that owns the response.
REQ-014 The module SHALL have port `resp_result_o`, output, 32 bits: the registered result.
REQ-015 The module SHALL have port `resp_zero_o`, output, 1 bit: the registered zero flag.
REQ-016 The module SHALL have port `busy_o`, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-017 The module SHALL have port `op_count_o`, output, 16 bits: count of completed response handshakes, wrapping.

Function
REQ-018 The FSM SHALL have three states: IDLE, EXEC, RESP; one operation is outstanding at a time.
REQ-019 IDLE: when at least one valid is high, the FSM SHALL grant exactly one requester, assert its ready combinationally in that cycle, latch its src1/src2/ctrl/id, and go to EXEC.
REQ-020 Arbitration SHALL be round-robin: priority pointer `ptr`; if both valids are high, grant `ptr`; if only one is high, grant it regardless of `ptr`.
REQ-021 `ptr` SHALL become the non-granted index on each grant and SHALL hold otherwise.
REQ-022 The ready outputs SHALL be 0 in EXEC and RESP; both SHALL never be high together.
REQ-023 In EXEC, `alu_src1_o`/`alu_src2_o`/`alu_ctrl_o` SHALL equal the latched values, and `alu_result_i`/`alu_zero_i` SHALL be registered into `resp_result_o`/`resp_zero_o` at the end of the cycle; the FSM SHALL then go to RESP.
REQ-024 Outside EXEC, the ALU outputs SHALL be 32'd0, 32'd0 and 4'hF (nop).
REQ-025 In RESP, `resp_valid_o` SHALL be 1 and the id/result/zero outputs SHALL be stable until `resp_ready_i` is sampled high.
REQ-026 On the RESP handshake, the FSM SHALL return to IDLE and `op_count_o` SHALL increment by 1 (0xFFFF wraps to 0x0000).
REQ-027 Timing: acceptance in cycle N SHALL give `resp_valid_o` high in cycle N+2; with `resp_ready_i` tied high, the sustained throughput SHALL be one operation per 3 cycles.
REQ-028 A request whose valid drops before its ready SHALL be ignored with no state change; requesters hold operands stable while valid is high.
REQ-029 Ctrl codes 9–15 SHALL be forwarded unchanged; the response is result 0, zero 1, which is a normal response.
REQ-030 A new request arriving while the FSM is in RESP SHALL wait until IDLE; there is no same-cycle bypass from RESP to grant.

Reset
REQ-031 While `rst_i` is high, the block SHALL asynchronously force: state IDLE, `ptr` 0, both readys 0, `resp_valid_o` 0, `resp_id_o` 0, `resp_result_o` 0, `resp_zero_o` 0, `busy_o` 0, `op_count_o` 0, and ALU outputs 0/0/F.
REQ-032 Reset asserted in EXEC or RESP SHALL abort the operation with no response emitted; after release, the block SHALL be in IDLE and accept a new request in the first edge.

Verification
REQ-033 Scenario: req0 add 5+7, resp_ready_i=1 -> ready0 high in cycle N, `resp_valid_o` in N+2, result 12, zero 0, id 0, `op_count_o` 1.
REQ-034 Scenario: both valid at once after reset (req0 sub 9-9, req1 or 0xF0|0x0F) -> req0 is granted first (result 0, zero 1), then req1 (result 0xFF, id 1); `ptr` ends at 0.
REQ-035 Scenario: `resp_ready_i` held low 5 cycles in RESP with req1 valid -> response stable for all 5 cycles, ready1 stays 0, and req1 is granted the cycle after IDLE is re-entered.
REQ-036 Scenario: `op_count_o` preset to 0xFFFF via 65535 ops (or forced), then one more op -> 0x0000.
REQ-037 Scenario: `rst_i` pulsed mid-EXEC on a mult 3*4 -> no `resp_valid_o`, all outputs at reset values, `busy_o` 0.
REQ-038 Scenario: req0 ctrl 4'hC -> `alu_ctrl_o`=C in EXEC; response result 0, zero 1.
